// File: rtl/alu_seq.sv
// Registered ALU with status flags, a multi-cycle restoring divider and
// valid/ready handshakes on both the operand and the result side.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] rem_out,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_dz,
    output logic             flag_ill
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [3:0] OP_ZERO = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_XNOR = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_NOTB = 4'b1101;
    localparam logic [3:0] OP_NOTA = 4'b1110;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             accept;
    logic             div_go;
    logic             div_done;

    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] div_d;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_diff;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [PW-1:0]    prod_w;

    logic             load_out;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] rem_nxt;
    logic             carry_nxt;
    logic             ovf_nxt;
    logic             dz_nxt;
    logic             ill_nxt;

    // Handshake: accept only when idle and the result slot is free or draining
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign div_go   = accept && (sel == OP_DIV) && (b != '0);
    assign div_done = (state == S_DIV) && (cnt == CW'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (div_go)   state_nxt = S_DIV;
            S_DIV:  if (div_done) state_nxt = S_IDLE;
            default:              state_nxt = S_IDLE;
        endcase
    end

    // One restoring divide step: shift in the next dividend bit, try subtracting
    always_comb begin
        r_shift = {div_r, div_q[WIDTH-1]};
        r_diff  = r_shift - {1'b0, div_d};
        if (!r_diff[WIDTH]) begin
            r_step = r_diff[WIDTH-1:0];
            q_step = {div_q[WIDTH-2:0], 1'b1};
        end else begin
            r_step = r_shift[WIDTH-1:0];
            q_step = {div_q[WIDTH-2:0], 1'b0};
        end
    end

    // Arithmetic operands widened for carry/borrow and the full product
    always_comb begin
        sum_w  = {1'b0, a} + {1'b0, b};
        dif_w  = {1'b0, a} - {1'b0, b};
        prod_w = PW'(a) * PW'(b);
    end

    // Output logic: what (if anything) loads into the result registers
    always_comb begin
        load_out  = 1'b0;
        res_nxt   = '0;
        rem_nxt   = '0;
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        dz_nxt    = 1'b0;
        ill_nxt   = 1'b0;
        if (div_done) begin
            load_out = 1'b1;
            res_nxt  = q_step;
            rem_nxt  = r_step;
        end else if (accept && !div_go) begin
            load_out = 1'b1;
            unique case (sel)
                OP_ZERO: res_nxt = '0;
                OP_ADD: begin
                    res_nxt   = sum_w[WIDTH-1:0];
                    carry_nxt = sum_w[WIDTH];
                    ovf_nxt   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB: begin
                    res_nxt   = dif_w[WIDTH-1:0];
                    carry_nxt = dif_w[WIDTH];
                    ovf_nxt   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
                end
                OP_MUL: begin
                    res_nxt   = prod_w[WIDTH-1:0];
                    carry_nxt = |prod_w[PW-1:WIDTH];
                end
                // Only the divide-by-zero case reaches here; real divides go to DIV
                OP_DIV: begin
                    res_nxt = '1;
                    rem_nxt = a;
                    dz_nxt  = 1'b1;
                end
                OP_SHL: begin
                    res_nxt   = {a[WIDTH-2:0], 1'b0};
                    carry_nxt = a[WIDTH-1];
                end
                OP_SHR: begin
                    res_nxt   = {1'b0, b[WIDTH-1:1]};
                    carry_nxt = b[0];
                end
                OP_AND:  res_nxt = a & b;
                OP_OR:   res_nxt = a | b;
                OP_XOR:  res_nxt = a ^ b;
                OP_NOR:  res_nxt = ~(a | b);
                OP_XNOR: res_nxt = ~(a ^ b);
                OP_NAND: res_nxt = ~(a & b);
                OP_NOTB: res_nxt = ~b;
                OP_NOTA: res_nxt = ~a;
                default: ill_nxt = 1'b1;
            endcase
        end
    end

    // Divider working registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            div_r <= '0;
            div_d <= '0;
            cnt   <= '0;
        end else if (div_go) begin
            div_q <= a;
            div_r <= '0;
            div_d <= b;
            cnt   <= CW'(WIDTH);
        end else if (state == S_DIV) begin
            div_q <= q_step;
            div_r <= r_step;
            cnt   <= cnt - CW'(1);
        end
    end

    // Result registers: load a new result, otherwise hold until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            alu_out    <= '0;
            rem_out    <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_dz    <= 1'b0;
            flag_ill   <= 1'b0;
        end else if (load_out) begin
            out_valid  <= 1'b1;
            alu_out    <= res_nxt;
            rem_out    <= rem_nxt;
            flag_zero  <= (res_nxt == '0);
            flag_carry <= carry_nxt;
            flag_ovf   <= ovf_nxt;
            flag_dz    <= dz_nxt;
            flag_ill   <= ill_nxt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios plus random ops against an arithmetic model.
module tb_alu_seq;

    localparam int unsigned W  = 8;
    localparam int unsigned VW = 2 * W + 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic [W-1:0] rem_out;
    logic         flag_zero;
    logic         flag_carry;
    logic         flag_ovf;
    logic         flag_dz;
    logic         flag_ill;

    int n_assert = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .rem_out    (rem_out),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf),
        .flag_dz    (flag_dz),
        .flag_ill   (flag_ill)
    );

    always #5 clk = ~clk;

    // Result bundle: {alu_out, rem_out, zero, carry, ovf, dz, ill}
    function automatic logic [VW-1:0] mk(int unsigned res, int unsigned rem,
                                         bit z, bit c, bit o, bit dz, bit ill);
        return {W'(res), W'(rem), z, c, o, dz, ill};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {alu_out, rem_out, flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill};
    endfunction

    // Reference model from the opcode definitions, in plain integer arithmetic
    function automatic logic [VW-1:0] ref_op(int unsigned op, int unsigned x, int unsigned y);
        int unsigned m  = 1 << W;
        int unsigned r  = 0;
        int unsigned rm = 0;
        bit c = 0, o = 0, dz = 0, ill = 0;
        int sx, sy, sr;
        sx = (x >= m / 2) ? int'(x) - int'(m) : int'(x);
        sy = (y >= m / 2) ? int'(y) - int'(m) : int'(y);
        case (op)
            0: r = 0;
            1: begin
                r = (x + y) % m; c = (x + y) >= m;
                sr = sx + sy; o = (sr > int'(m / 2) - 1) || (sr < -int'(m / 2));
            end
            2: begin
                r = (x + m - y) % m; c = x < y;
                sr = sx - sy; o = (sr > int'(m / 2) - 1) || (sr < -int'(m / 2));
            end
            3: begin r = (x * y) % m; c = (x * y) >= m; end
            4: begin
                if (y == 0) begin r = m - 1; rm = x; dz = 1; end
                else begin r = x / y; rm = x % y; end
            end
            5: begin r = (x * 2) % m; c = x >= m / 2; end
            6: begin r = y / 2; c = (y % 2) == 1; end
            7:  r = x & y;
            8:  r = x | y;
            9:  r = x ^ y;
            10: r = (m - 1) & ~(x | y);
            11: r = (m - 1) & ~(x ^ y);
            12: r = (m - 1) & ~(x & y);
            13: r = (m - 1) & ~y;
            14: r = (m - 1) & ~x;
            default: ill = 1;
        endcase
        return mk(r, rm, r == 0, c, o, dz, ill);
    endfunction

    task automatic check(string tag, logic [63:0] o, logic [63:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Present an op at the falling edge and leave 1 time unit after the accept edge
    task automatic issue(logic [3:0] s, logic [W-1:0] x, logic [W-1:0] y);
        int guard = 0;
        @(negedge clk);
        sel = s; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("issue_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count extra edges after the accept edge until out_valid is seen
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        logic [3:0]   s;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           lat;

        in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 64'(obs()), 64'(mk(0, 0, 0, 0, 0, 0, 0)));
        check("rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);

        issue(4'b0001, 8'hF0, 8'h20);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add", 64'(obs()), 64'(mk('h10, 0, 0, 1, 0, 0, 0)));

        issue(4'b0010, 8'h80, 8'h01);
        check("sub_ovf", 64'(obs()), 64'(mk('h7F, 0, 0, 0, 1, 0, 0)));
        issue(4'b0010, 8'h03, 8'h05);
        check("sub_borrow", 64'(obs()), 64'(mk('hFE, 0, 0, 1, 0, 0, 0)));

        issue(4'b0100, 8'd200, 8'd7);
        check("div_busy0", 64'(in_ready), 64'd0);
        check("div_pend0", 64'(out_valid), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 8) begin
                check("div_busy", 64'(in_ready), 64'd0);
                check("div_pend", 64'(out_valid), 64'd0);
            end
        end
        check("div_valid", 64'(out_valid), 64'd1);
        check("div", 64'(obs()), 64'(mk(28, 4, 0, 0, 0, 0, 0)));

        issue(4'b0100, 8'd9, 8'd0);
        check("div0_valid", 64'(out_valid), 64'd1);
        check("div0", 64'(obs()), 64'(mk('hFF, 9, 0, 0, 0, 1, 0)));

        // Backpressure, then a simultaneous drain and new accept
        issue(4'b0111, 8'h3C, 8'h0F);
        out_ready = 1'b0;
        check("and", 64'(obs()), 64'(mk('h0C, 0, 0, 0, 0, 0, 0)));
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_hold", 64'(obs()), 64'(mk('h0C, 0, 0, 0, 0, 0, 0)));
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; sel = 4'b1101; a = '0; b = 8'h0F; in_valid = 1'b1;
        #1;
        check("bp_ready_up", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b", 64'(obs()), 64'(mk('hF0, 0, 0, 0, 0, 0, 0)));

        // Asynchronous reset in the middle of a divide
        issue(4'b0100, 8'd255, 8'd3);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out", 64'(obs()), 64'(mk(0, 0, 0, 0, 0, 0, 0)));
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_ready", 64'(in_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_stale", 64'(out_valid), 64'd0);
        issue(4'b0000, 8'h55, 8'hAA);
        check("zero_op", 64'(obs()), 64'(mk(0, 0, 1, 0, 0, 0, 0)));

        issue(4'b1111, 8'h12, 8'h34);
        check("illegal", 64'(obs()), 64'(mk(0, 0, 1, 0, 0, 0, 1)));
        issue(4'b0011, 8'h10, 8'h10);
        check("mul_carry", 64'(obs()), 64'(mk(0, 0, 1, 1, 0, 0, 0)));

        // Random ops with occasional consumer stalls
        for (int i = 0; i < 80; i++) begin
            s = 4'($urandom_range(0, 15));
            x = W'($urandom_range(0, 255));
            y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
            issue(s, x, y);
            wait_result(lat);
            check("rnd_lat", 64'(lat), ((s == 4'b0100) && (y != '0)) ? 64'(W) : 64'd0);
            check("rnd", 64'(obs()), 64'(ref_op(s, x, y)));
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                check("rnd_hold", 64'(obs()), 64'(ref_op(s, x, y)));
                check("rnd_hold_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU; keeps the same 4-bit opcode map.
- Adds WIDTH generalisation, status flags, a multi-cycle restoring divider with remainder, and valid/ready handshakes on input and output.
- Sits between an operand-issuing controller and a result consumer; exactly one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- sel  input  4  opcode
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  consumer accepts the result
- alu_out  output  WIDTH  result
- rem_out  output  WIDTH  remainder (divide only, else 0)
- flag_zero  output  1  alu_out == 0
- flag_carry  output  1  carry/borrow/shifted-out bit
- flag_ovf  output  1  signed overflow (add/sub only)
- flag_dz  output  1  divide by zero
- flag_ill  output  1  illegal opcode

Behaviour:
- Reset (asynchronous, any time including mid-divide): state=IDLE; out_valid, alu_out, rem_out and all flags = 0; the divide in flight is discarded. in_ready = 1 after reset release.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An operation is accepted on a rising edge where in_valid && in_ready.
- Output holds: alu_out, rem_out, flags and out_valid stay stable until a clock edge with out_valid && out_ready. At that edge out_valid clears unless a new single-cycle result loads at the same edge, in which case out_valid stays 1 with the new data.
- Opcodes (arithmetic is modulo 2^WIDTH; flags default 0):
  - 0000: result 0.
  - 0001: a+b; carry = bit WIDTH of the sum; ovf = signed overflow.
  - 0010: a-b; carry = borrow (a<b); ovf = signed overflow.
  - 0011: a*b, low WIDTH bits; carry = 1 if the high half is nonzero.
  - 0100: a/b, rem_out = a%b (multi-cycle, see divider).
  - 0101: a<<1; carry = a[WIDTH-1].
  - 0110: b>>1; carry = b[0].
  - 0111: a&b. 1000: a|b. 1001: a^b. 1010: ~(a|b). 1011: ~(a^b). 1100: ~(a&b). 1101: ~b. 1110: ~a.
  - 1111: illegal; result 0, flag_ill = 1, completes as a single-cycle op.
- Single-cycle ops: the result and flags are registered at the accept edge, so out_valid is high in the following cycle (latency 1).
- Divider FSM (states IDLE, DIV):
  - Accept with sel=0100 and b!=0: latch a and b, load the iteration counter with WIDTH, go to DIV.
  - DIV: one restoring quotient bit per cycle, MSB first. On the WIDTH-th iteration edge, load alu_out and rem_out, set out_valid, return to IDLE. Out_valid rises WIDTH edges after the accept edge.
  - in_ready = 0 throughout DIV.
  - The output register is guaranteed empty at completion, by the in_ready rule.
- Divide by zero: with b==0, no DIV state is entered. The block completes in 1 cycle with alu_out = all ones, rem_out = a, flag_dz = 1.
- flag_zero is evaluated on the final alu_out for every op, including divide and illegal.
- in_valid while in_ready=0 is ignored; the source must hold its request.

Test Plan:
- WIDTH=8, reset, accept sel=0001 a=0xF0 b=0x20 -> next cycle out_valid=1, alu_out=0x10, carry=1, ovf=0, zero=0.
- sel=0010 a=0x80 b=0x01 -> alu_out=0x7F, carry=0, ovf=1. Then sel=0010 a=0x03 b=0x05 -> alu_out=0xFE, carry=1.
- sel=0100 a=200 b=7 -> in_ready=0 for 8 cycles; out_valid rises exactly 8 edges after accept with alu_out=28, rem_out=4. Then a=9 b=0 -> 1-cycle result alu_out=0xFF, rem_out=9, dz=1.
- Backpressure: hold out_ready=0 after an 0111 op -> alu_out and out_valid hold and in_ready=0. Raise out_ready together with a new in_valid (sel=1101, b=0x0F) -> back-to-back results; the second is alu_out=0xF0.
- Assert rst at divide iteration 4 of a=255 b=3 -> all outputs 0 immediately (asynchronously); after release, in_ready=1 and the next op (sel=0000) gives alu_out=0, zero=1.
- sel=1111 -> flag_ill=1, alu_out=0. sel=0011 a=0x10 b=0x10 -> alu_out=0x00, carry=1, zero=1.
